// File: rtl/tiempo_base.sv
// tiempo_base: prescaled seconds/minutes/hours/day clock with pause, load and tick pulses
module tiempo_base #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int ACCEL     = 60,
  parameter int HORAS_DIA = 24,
  parameter int DIA_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acelerar,
  input  logic             pausa,
  input  logic             cargar,
  input  logic [4:0]       hora_in,
  input  logic [5:0]       min_in,
  output logic [5:0]       seg,
  output logic [5:0]       minuto,
  output logic [4:0]       hora,
  output logic [DIA_W-1:0] dia,
  output logic             tick_seg,
  output logic             tick_min,
  output logic             tick_hora,
  output logic             led
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam int LA = CLK_HZ / ACCEL > 1 ? CLK_HZ / ACCEL : 1;
  logic [PW-1:0] pre;
  logic [31:0] lim;
  logic fin, carga_ok, fin_seg, fin_min, fin_hora;
  always_comb begin
    lim      = acelerar ? 32'(LA) : 32'(CLK_HZ);
    fin      = 32'(pre) >= lim - 32'd1;
    carga_ok = cargar && 32'(hora_in) < 32'(HORAS_DIA) && min_in < 6'd60;
    fin_seg  = seg == 6'd59;
    fin_min  = minuto == 6'd59;
    fin_hora = hora == 5'(HORAS_DIA - 1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pre <= '0;
      {seg, minuto, hora, dia} <= '0;
      {tick_seg, tick_min, tick_hora, led} <= '0;
    end else if (carga_ok) begin
      pre <= '0;
      seg <= '0;
      minuto <= min_in;
      hora <= hora_in;
      {tick_seg, tick_min, tick_hora} <= '0;
    end else if (pausa) begin
      {tick_seg, tick_min, tick_hora} <= '0;
    end else if (!fin) begin
      pre <= pre + 1'b1;
      {tick_seg, tick_min, tick_hora} <= '0;
    end else begin
      pre <= '0;
      tick_seg <= 1'b1;
      tick_min <= fin_seg;
      tick_hora <= fin_seg && fin_min;
      led <= ~led;
      seg <= fin_seg ? 6'd0 : seg + 6'd1;
      if (fin_seg) minuto <= fin_min ? 6'd0 : minuto + 6'd1;
      if (fin_seg && fin_min) hora <= fin_hora ? 5'd0 : hora + 5'd1;
      if (fin_seg && fin_min && fin_hora) dia <= dia + 1'b1;
    end
endmodule

// File: doc/tiempo_base.md
Name: tiempo_base

Overview:
- Parametrised real-time base for the pet/game core.
- Divides the system clock to a 1 Hz second tick, with a selectable accelerated rate for demo/testing.
- Maintains a seconds/minutes/hours/day clock, which can be paused and loaded.
- Emits one-cycle tick pulses that consumer blocks (hunger, sleep, energy timers) use as clock enables.
- Replaces the single free-running divider and counter with a settable, multi-field clock.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; prescaler terminal count for normal mode.
- ACCEL, 60, speed-up factor when acelerar=1; second period becomes CLK_HZ/ACCEL cycles (integer division, minimum 1).
- HORAS_DIA, 24, hours per day; hora wraps at HORAS_DIA-1.
- DIA_W, 8, width of the day counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- acelerar  in  1  1 = accelerated rate, 0 = real time.
- pausa  in  1  1 = freeze prescaler and all time fields.
- cargar  in  1  single-cycle load strobe for hora_in/min_in.
- hora_in  in  5  hour value to load.
- min_in  in  6  minute value to load.
- seg  out  6  seconds, 0..59.
- minuto  out  6  minutes, 0..59.
- hora  out  5  hours, 0..HORAS_DIA-1.
- dia  out  DIA_W  elapsed days, wraps modulo 2^DIA_W.
- tick_seg  out  1  one-cycle pulse on each second increment.
- tick_min  out  1  one-cycle pulse when seg wraps 59->0.
- tick_hora  out  1  one-cycle pulse when minuto wraps 59->0.
- led  out  1  heartbeat; toggles on every tick_seg.

Behaviour:
- Reset (rst=0, async): prescaler=0, seg=0, minuto=0, hora=0, dia=0, all ticks=0, led=0. All outputs are registered.
- Limit L = acelerar ? max(CLK_HZ/ACCEL,1) : CLK_HZ. Prescaler width = clog2(CLK_HZ).
- Each cycle with pausa=0 and cargar=0:
  - If prescaler >= L-1: prescaler <= 0 and a second-advance occurs.
  - Otherwise prescaler increments.
- Toggling acelerar mid-count takes effect immediately. If the prescaler is already >= new L-1, the advance occurs on the next edge. There is no backlog of missed ticks.
- Second-advance sequencing:
  - seg increments, with tick_seg=1 and led toggling.
  - seg==59: seg<=0, minuto increments, tick_min=1.
  - Also minuto==59: minuto<=0, hora increments, tick_hora=1.
  - Also hora==HORAS_DIA-1: hora<=0, dia increments (wraps at 2^DIA_W, no flag).
  - All fields update on the same edge. Tick pulses are registered: high exactly one cycle, in the cycle where the new field values are first visible.
- pausa=1: prescaler and all fields hold, ticks=0, led holds. On release, counting resumes from the held prescaler value.
- cargar=1 (priority over pausa and any advance in the same cycle):
  - If hora_in < HORAS_DIA and min_in < 60: hora<=hora_in, minuto<=min_in, seg<=0, prescaler<=0. dia is unchanged.
  - Otherwise the load is ignored and counting continues normally that cycle.
  - No tick pulses are produced in a load cycle.
- cargar held high for several cycles reloads every cycle, so time does not advance.
- Reset mid-second discards the partial prescaler count.

Test Plan:
- CLK_HZ=10, ACCEL=5, acelerar=0: release reset, run 25 cycles -> tick_seg pulses at cycles 10 and 20 (one cycle wide), seg=2, led=0 after two toggles.
- acelerar=1 from reset: tick_seg every 2 cycles. At prescaler=7, switch acelerar 0->1 -> tick on the next edge, then every 2 cycles.
- Load hora_in=23, min_in=59, then advance 59 seconds, then one more -> on that edge seg=0, minuto=0, hora=0, dia=1; tick_seg, tick_min and tick_hora are all high in the same single cycle.
- Invalid load hora_in=24, min_in=10 -> fields unchanged, counting continues. Valid load coincident with the terminal prescaler count -> loaded values appear, seg=0, no tick pulse.
- pausa=1 for 30 cycles mid-second at prescaler=4 -> no ticks, outputs frozen. After release, the first tick comes 6 cycles later (normal mode).
- Assert rst=0 asynchronously between clock edges with seg=37 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first tick comes at cycle 10.
